input_buffer_sync: RTL and testbench

//  Parametrised, registered input peripheral for the single-cycle core's LSU load path.
//  - Synchronises NUM_SW switches and NUM_BTN buttons.
//  - Debounces the buttons.
//  - Latches button rising edges in a write-1-to-clear pending register that drives o_btn_irq.
//  - Serves LB/LH/LW/LBU/LHU reads over the 8-bit I/O input window (0x00-0x1F).

---
 rtl/input_buffer_sync_if.sv | 19 +
 rtl/input_buffer_sync.sv | 128 ++++++++++++
 tb/tb_input_buffer_sync.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/input_buffer_sync_if.sv
// Load/store bus between the LSU and the input peripheral's 0x00-0x1F window.
interface input_buffer_sync_if;
  logic [2:0]  i_control;
  logic [7:0]  i_in_buf_addr;
  logic        i_wren;
  logic [31:0] i_wr_data;
  logic [31:0] o_in_buf_data;
  logic        o_btn_irq;

  modport master (
    output i_control, i_in_buf_addr, i_wren, i_wr_data,
    input  o_in_buf_data, o_btn_irq
  );

  modport slave (
    input  i_control, i_in_buf_addr, i_wren, i_wr_data,
    output o_in_buf_data, o_btn_irq
  );
endinterface

// File: rtl/input_buffer_sync.sv
// Synchronised switches, debounced buttons with W1C rising-edge pending bits,
// and a byte-addressable read window serving LB/LH/LW/LBU/LHU.
module input_buffer_sync #(
  parameter int NUM_SW      = 32,
  parameter int NUM_BTN     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 50000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_SW-1:0]   i_io_sw,
  input  logic [NUM_BTN-1:0]  i_io_btn,
  input_buffer_sync_if.slave  bus
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0][NUM_SW-1:0]  sw_sync;
  logic [SYNC_STAGES-1:0][NUM_BTN-1:0] btn_sync;
  logic [NUM_SW-1:0]                   sw_s;
  logic [NUM_BTN-1:0]                  btn_s;

  logic [NUM_BTN-1:0]         stable, stable_nxt;
  logic [NUM_BTN-1:0][CW-1:0] cnt, cnt_nxt;
  logic [NUM_BTN-1:0]         pending, pending_nxt;
  logic [NUM_BTN-1:0]         clr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and the chain shifts one stage per clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_sync  <= '0;
      btn_sync <= '0;
    end else begin
      sw_sync[0]  <= i_io_sw;
      btn_sync[0] <= i_io_btn;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sw_sync[k]  <= sw_sync[k-1];
        btn_sync[k] <= btn_sync[k-1];
      end
    end
  end

  assign sw_s  = sw_sync[SYNC_STAGES-1];
  assign btn_s = btn_sync[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = cnt;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn_s[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        stable_nxt[i] = btn_s[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  // Rising edges of the debounced level set bits; a same-cycle clear loses.
  assign clr = (bus.i_wren && bus.i_in_buf_addr[7:2] == 6'h05)
             ? bus.i_wr_data[NUM_BTN-1:0] : '0;
  assign pending_nxt = (pending & ~clr) | (stable_nxt & ~stable);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable  <= '0;
      cnt     <= '0;
      pending <= '0;
    end else begin
      stable  <= stable_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
    end
  end

  assign bus.o_btn_irq = |pending;

  logic [7:0]       win [32];
  logic [31:0]      sw_ext;
  logic [7:0]       base;
  logic [7:0]       ea;
  logic [3:0][7:0]  rd;

  assign sw_ext = 32'(sw_s);

  always_comb begin
    for (int i = 0; i < 32; i++) win[i] = '0;
    for (int i = 0; i < 4; i++)  win[i] = sw_ext[8*i +: 8];
    win[16] = 8'(stable);
    win[20] = 8'(pending);
  end

  // Misaligned halfword/word accesses are forced down to the aligned base.
  always_comb begin
    case (bus.i_control[1:0])
      2'b00:   base = bus.i_in_buf_addr;
      2'b01:   base = bus.i_in_buf_addr & 8'hFE;
      default: base = bus.i_in_buf_addr & 8'hFC;
    endcase
  end

  always_comb begin
    ea = '0;
    rd = '0;
    for (int k = 0; k < 4; k++) begin
      ea    = base + 8'(k);
      rd[k] = (ea[7:5] == 3'b000) ? win[ea[4:0]] : 8'h00;
    end
  end

  always_comb begin
    case (bus.i_control)
      3'b000:  bus.o_in_buf_data = {{24{rd[0][7]}}, rd[0]};
      3'b001:  bus.o_in_buf_data = {{16{rd[1][7]}}, rd[1], rd[0]};
      3'b010:  bus.o_in_buf_data = {rd[3], rd[2], rd[1], rd[0]};
      3'b100:  bus.o_in_buf_data = {24'h0, rd[0]};
      3'b101:  bus.o_in_buf_data = {16'h0, rd[1], rd[0]};
      default: bus.o_in_buf_data = 32'h0;
    endcase
  end

  logic unused_wr_bits;
  assign unused_wr_bits = ^bus.i_wr_data[31:NUM_BTN];
endmodule

// File: tb/tb_input_buffer_sync.sv
// Directed bench for input_buffer_sync with DB_CYCLES=4: expectations are queued
// when stimulus is applied and popped when the DUT output is sampled.
module tb_input_buffer_sync;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010,
                         LBU = 3'b100, LHU = 3'b101, BAD = 3'b011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sw;
  logic [3:0]  btn;

  input_buffer_sync_if bus();

  input_buffer_sync #(
    .NUM_SW(32), .NUM_BTN(4), .SYNC_STAGES(2), .DB_CYCLES(4)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_io_sw  (sw),
    .i_io_btn (btn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%h with no expected value queued", tag, obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] f, input logic [7:0] a,
                      input logic [31:0] exp, input string tag);
    bus.i_control     = f;
    bus.i_in_buf_addr = a;
    sb.push_back('{tag, exp});
    #1;
    check(tag, bus.o_in_buf_data);
  endtask

  task automatic irq(input logic exp, input string tag);
    sb.push_back('{tag, {31'h0, exp}});
    check(tag, {31'h0, bus.o_btn_irq});
  endtask

  task automatic store(input logic [7:0] a, input logic [31:0] d);
    bus.i_wren        = 1'b1;
    bus.i_in_buf_addr = a;
    bus.i_wr_data     = d;
    cycles(1);
    bus.i_wren        = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    // Reset with every input driven high.
    rst_n = 1'b0;
    sw = '1;
    btn = '1;
    bus.i_wren = 1'b1;
    bus.i_wr_data = '1;
    bus.i_control = LW;
    bus.i_in_buf_addr = 8'h14;
    cycles(2);
    load(LW, 8'h00, 32'h0, "rst_lw00");
    load(LBU, 8'h10, 32'h0, "rst_btn");
    irq(1'b0, "rst_irq");
    btn = '0;
    bus.i_wren = 1'b0;
    rst_n = 1'b1;
    cycles(1);
    load(LW, 8'h00, 32'h0, "sync_1clk");
    cycles(1);
    load(LW, 8'h00, 32'hFFFF_FFFF, "sync_2clk");

    // Switch extraction.
    sw = 32'h80FF_7F81;
    cycles(2);
    load(LB,  8'h00, 32'hFFFF_FF81, "lb_00");
    load(LBU, 8'h03, 32'h0000_0080, "lbu_03");
    load(LH,  8'h02, 32'hFFFF_80FF, "lh_02");
    load(LHU, 8'h01, 32'h0000_7F81, "lhu_01");
    load(LW,  8'h02, 32'h80FF_7F81, "lw_02");

    // Glitching button never reaches the stable level.
    btn = 4'h1; cycles(1);
    btn = 4'h0; cycles(1);
    btn = 4'h1; cycles(1);
    btn = 4'h0; cycles(6);
    load(LBU, 8'h10, 32'h0, "glitch_stable");
    irq(1'b0, "glitch_irq");

    // Held button is accepted exactly 2+4 cycles later.
    btn = 4'h1;
    cycles(5);
    load(LBU, 8'h10, 32'h0, "hold_5");
    irq(1'b0, "hold_5_irq");
    cycles(1);
    load(LBU, 8'h10, 32'h1, "hold_6_stable");
    load(LBU, 8'h14, 32'h1, "hold_6_pending");
    irq(1'b1, "hold_6_irq");

    // W1C clear of both bits in the cycle btn[1] is accepted: set wins.
    btn = 4'h3;
    cycles(5);
    load(LBU, 8'h10, 32'h1, "b1_not_yet");
    store(8'h14, 32'h3);
    load(LBU, 8'h14, 32'h2, "w1c_setwins");
    load(LBU, 8'h10, 32'h3, "b1_stable");
    irq(1'b1, "w1c_irq1");
    store(8'h16, 32'h2);
    load(LBU, 8'h14, 32'h0, "w1c_clr16");
    irq(1'b0, "w1c_irq0");

    // Release of btn[0] sets nothing; press btn[2] sets bit 2.
    btn = 4'h2;
    cycles(7);
    load(LBU, 8'h10, 32'h2, "fall_stable");
    load(LBU, 8'h14, 32'h0, "fall_nopend");
    btn = 4'h6;
    cycles(6);
    load(LBU, 8'h14, 32'h4, "b2_pending");
    store(8'h10, 32'hF);
    load(LBU, 8'h14, 32'h4, "st10_ignored");
    store(8'h18, 32'hF);
    load(LBU, 8'h14, 32'h4, "st18_ignored");
    irq(1'b1, "ignored_irq");

    // Out-of-range, unmapped and illegal func3.
    load(LW,  8'h20, 32'h0, "lw_20");
    load(LBU, 8'h1F, 32'h0, "lbu_1f");
    load(BAD, 8'h00, 32'h0, "func3_011");
    cycles(1);
    load(LW,  8'h11, 32'h6, "lw_10_misal");
    load(LW,  8'h14, 32'h4, "lw_14");
    load(LB,  8'h03, 32'hFFFF_FF80, "lb_03");
    load(LH,  8'h13, 32'h0, "lh_12");
    load(LBU, 8'h14, 32'h4, "read_noside");

    // Reset while btn[3]'s counter is at 2.
    btn = 4'hE;
    cycles(4);
    rst_n = 1'b0;
    #1;
    load(LBU, 8'h10, 32'h0, "midrst_stable");
    load(LBU, 8'h14, 32'h0, "midrst_pending");
    irq(1'b0, "midrst_irq");
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    load(LBU, 8'h14, 32'h0, "postrst_5");
    irq(1'b0, "postrst_5_irq");
    cycles(1);
    load(LBU, 8'h14, 32'hE, "postrst_6_pending");
    load(LBU, 8'h10, 32'hE, "postrst_6_stable");
    irq(1'b1, "postrst_6_irq");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
